// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its surroundings: hazard/redirect
// controls, the instruction ROM port and the IF/ID register outputs.
interface fetch_unit_if #(
  parameter int ADDR_W = 15
) ();
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic [31:0]       imem_instr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       pc;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic              id_valid;
  logic              misalign_err;
  logic [31:0]       fetch_count;

  modport master (
    input  stall, redirect, redirect_target, imem_instr,
    output imem_addr, pc, id_instr, id_pc, id_valid, misalign_err, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_target, imem_instr,
    input  imem_addr, pc, id_instr, id_pc, id_valid, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, ROM addressing and the IF/ID
// pipeline register, with stall, redirect/flush and a fetch counter.
module fetch_unit #(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int PC_W = ADDR_W + 2;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [31:0]     id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     count_q, count_d;

  // Target bits above the PC width are dropped by design.
  logic unused_tgt_hi;
  assign unused_tgt_hi = ^bus.redirect_target[31:PC_W];

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    misalign_d = 1'b0;
    count_d    = count_q;
    if (bus.redirect) begin
      pc_d       = {bus.redirect_target[PC_W-1:2], 2'b00};
      id_instr_d = NOP;
      id_pc_d    = 32'h0;
      id_valid_d = 1'b0;
      misalign_d = |bus.redirect_target[1:0];
    end else if (!bus.stall) begin
      id_instr_d = bus.imem_instr;
      id_pc_d    = 32'(pc_q);
      id_valid_d = 1'b1;
      pc_d       = pc_q + PC_W'(4);
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC[PC_W-1:0];
      id_instr_q <= NOP;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  // ROM address comes only from the PC register, keeping EX off the ROM path.
  assign bus.imem_addr    = pc_q[PC_W-1:2];
  assign bus.pc           = 32'(pc_q);
  assign bus.id_instr     = id_instr_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, wrap sequence, then random
// stall/redirect/reset traffic against a behavioural model.
module tb_fetch_unit;
  localparam int          ADDR_W = 15;
  localparam int unsigned PCMOD  = 32'h1 << (ADDR_W + 2);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input int unsigned waddr);
    return 32'hA500_0000 ^ (waddr * 32'h9E37_79B1) ^ (waddr << 7);
  endfunction

  // ROM registers its output on the falling edge.
  always @(negedge clk) bus.imem_instr <= rom_word(32'(bus.imem_addr));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit s, input bit d, input logic [31:0] t);
    rst_n               = r;
    bus.stall           = s;
    bus.redirect        = d;
    bus.redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                         input logic e_vld, input logic [31:0] e_instr, input logic e_mis,
                         input logic [31:0] e_cnt);
    chk({tag, ".pc"}, bus.pc, e_pc);
    chk({tag, ".imem_addr"}, 32'(bus.imem_addr), e_pc >> 2);
    chk({tag, ".id_pc"}, bus.id_pc, e_idpc);
    chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(e_vld));
    chk({tag, ".id_instr"}, bus.id_instr, e_instr);
    chk({tag, ".misalign"}, 32'(bus.misalign_err), 32'(e_mis));
    chk({tag, ".count"}, bus.fetch_count, e_cnt);
  endtask

  typedef struct {
    bit          r, s, d;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_idpc;
    bit          e_vld;
    logic [31:0] e_instr;
    bit          e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit d, logic [31:0] tgt, logic [31:0] e_pc,
                              logic [31:0] e_idpc, bit e_vld, logic [31:0] e_instr,
                              bit e_mis, logic [31:0] e_cnt);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.tgt = tgt;
    v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Behavioural model state
  logic [31:0] m_pc, m_idpc, m_instr, m_cnt;
  bit          m_vld, m_mis;

  task automatic model_step(input bit r, input bit s, input bit d, input logic [31:0] t);
    if (!r) begin
      m_pc = 0; m_idpc = 0; m_instr = NOP; m_vld = 0; m_mis = 0; m_cnt = 0;
    end else if (d) begin
      m_pc    = (t % PCMOD) & ~32'h3;
      m_instr = NOP; m_vld = 0; m_idpc = 0;
      m_mis   = (t % 4) != 0;
    end else if (s) begin
      m_mis = 0;
    end else begin
      m_instr = rom_word(m_pc / 4);
      m_idpc  = m_pc;
      m_vld   = 1;
      m_pc    = (m_pc + 4) % PCMOD;
      m_cnt   = m_cnt + 1;
      m_mis   = 0;
    end
  endtask

  vec_t vecs[$];

  initial begin
    // Reset, straight-line fetch, stall, redirects and reset overriding events
    vecs.push_back(mk(0,0,0,32'h0,      32'h0,  32'h0, 0, NOP, 0, 0));
    vecs.push_back(mk(0,0,0,32'h0,      32'h0,  32'h0, 0, NOP, 0, 0));
    vecs.push_back(mk(1,0,0,32'h0,      32'h4,  32'h0, 1, rom_word(0), 0, 1));
    vecs.push_back(mk(1,0,0,32'h0,      32'h8,  32'h4, 1, rom_word(1), 0, 2));
    vecs.push_back(mk(1,0,0,32'h0,      32'hC,  32'h8, 1, rom_word(2), 0, 3));
    vecs.push_back(mk(1,0,0,32'h0,      32'h10, 32'hC, 1, rom_word(3), 0, 4));
    vecs.push_back(mk(0,1,1,32'h80,     32'h0,  32'h0, 0, NOP, 0, 0));
    vecs.push_back(mk(0,0,0,32'h0,      32'h0,  32'h0, 0, NOP, 0, 0));
    vecs.push_back(mk(1,0,0,32'h0,      32'h4,  32'h0, 1, rom_word(0), 0, 1));
    vecs.push_back(mk(1,0,0,32'h0,      32'h8,  32'h4, 1, rom_word(1), 0, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,1,0,32'h0,    32'h8,  32'h4, 1, rom_word(1), 0, 2));
    vecs.push_back(mk(1,0,0,32'h0,      32'hC,  32'h8, 1, rom_word(2), 0, 3));
    vecs.push_back(mk(1,0,0,32'h0,      32'h10, 32'hC, 1, rom_word(3), 0, 4));
    vecs.push_back(mk(1,1,1,32'h40,     32'h40, 32'h0, 0, NOP, 0, 4));
    vecs.push_back(mk(1,0,0,32'h0,      32'h44, 32'h40,1, rom_word(16), 0, 5));
    vecs.push_back(mk(1,0,1,32'h42,     32'h40, 32'h0, 0, NOP, 1, 5));
    vecs.push_back(mk(1,0,0,32'h0,      32'h44, 32'h40,1, rom_word(16), 0, 6));
    vecs.push_back(mk(1,0,1,32'h80,     32'h80, 32'h0, 0, NOP, 0, 6));
    vecs.push_back(mk(1,0,1,32'h103,    32'h100,32'h0, 0, NOP, 1, 6));
    vecs.push_back(mk(1,0,0,32'h0,      32'h104,32'h100,1, rom_word(32'h40), 0, 7));
    vecs.push_back(mk(1,0,1,32'hFFFE0040,32'h40,32'h0, 0, NOP, 0, 7));
    vecs.push_back(mk(1,0,0,32'h0,      32'h44, 32'h40,1, rom_word(16), 0, 8));
    vecs.push_back(mk(1,0,1,32'h41,     32'h40, 32'h0, 0, NOP, 1, 8));
    vecs.push_back(mk(1,1,0,32'h0,      32'h40, 32'h0, 0, NOP, 0, 8));
    vecs.push_back(mk(1,0,0,32'h0,      32'h44, 32'h40,1, rom_word(16), 0, 9));

    rst_n = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].tgt);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_idpc, vecs[i].e_vld,
              vecs[i].e_instr, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // PC wrap at the top of the 17-bit address space
    apply(1, 0, 1, 32'h0001_FFFC);
    chk("wrap.pc_top", bus.pc, 32'h0001_FFFC);
    chk("wrap.addr_top", 32'(bus.imem_addr), 32'h7FFF);
    apply(1, 0, 0, 32'h0);
    chk("wrap.pc_zero", bus.pc, 32'h0);
    chk("wrap.addr_zero", 32'(bus.imem_addr), 32'h0);
    chk("wrap.id_pc", bus.id_pc, 32'h0001_FFFC);
    chk("wrap.id_instr", bus.id_instr, rom_word(32'h7FFF));
    chk("wrap.count", bus.fetch_count, 32'd10);

    // Randomized traffic against the model
    apply(0, 0, 0, 32'h0);
    model_step(0, 0, 0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      bit r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 63) != 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: t = $urandom;
        1: t = 32'h0001_FFF0 + $urandom_range(0, 15);
        default: t = $urandom_range(0, 255);
      endcase
      apply(r, s, d, t);
      model_step(r, s, d, t);
      chk_all("rand", m_pc, m_idpc, m_vld, m_instr, m_mis, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
